// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router.
package rom_dl_pkg;

  localparam int MAX_NREG = 8;

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_MERGE2 = 2'd1,
    MODE_MERGE4 = 2'd2
  } rom_dl_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } rom_dl_state_e;

endpackage

// File: rtl/rom_dl_router_if.sv
// SDRAM write-port bundle: two toggle req/ack pairs sharing one address/data bus.
interface rom_dl_router_if #(
  parameter int PW = 24
);

  logic          port1_req;
  logic          port2_req;
  logic          port1_ack;
  logic          port2_ack;
  logic [PW-1:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_d;

  modport master (
    output port1_req, port2_req, port_a, port_ds, port_d,
    input  port1_ack, port2_ack
  );

  modport slave (
    input  port1_req, port2_req, port_a, port_ds, port_d,
    output port1_ack, port2_ack
  );

endinterface

// File: rtl/rom_dl_addr_map.sv
// Region priority encoder, offset subtract and lane remap; the output register is the ISSUE stage.
module rom_dl_addr_map
  import rom_dl_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 25,
  parameter int PW   = 24
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      load,
  input  logic [AW-1:0]             addr,
  input  logic [NREG-1:0][AW-1:0]   region_base,
  input  logic [AW-1:0]             region_end,
  input  logic [NREG-1:0][1:0]      region_mode,
  input  logic [NREG-1:0][4:0]      region_shift,
  input  logic [NREG-1:0][PW-1:0]   region_dst,
  input  logic [NREG-1:0][1:0]      region_port,
  output logic                      in_range,
  output logic [1:0]                issue_mask,
  output logic [PW-1:0]             port_a,
  output logic [1:0]                mask_q
);

  logic [AW-1:0] off;
  logic [AW-1:0] lo_mask;
  logic [AW-1:0] mapped;
  logic [4:0]    s;
  logic [5:0]    s1;
  logic [5:0]    s2;
  logic [PW-1:0] dst;
  logic [1:0]    pmask;
  rom_dl_mode_e  mode;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    off   = addr - region_base[0];
    s     = region_shift[0];
    mode  = rom_dl_mode_e'(region_mode[0]);
    dst   = region_dst[0];
    pmask = region_port[0];
    // Later regions win: the table is ascending, so the last match is the enclosing region.
    for (int i = 1; i < NREG; i++) begin
      if (addr >= region_base[i]) begin
        off   = addr - region_base[i];
        s     = region_shift[i];
        mode  = rom_dl_mode_e'(region_mode[i]);
        dst   = region_dst[i];
        pmask = region_port[i];
      end
    end

    in_range = (addr >= region_base[0]) && (addr < region_end);

    lo_mask = (AW'(1) << s) - AW'(1);
    s1      = {1'b0, s} + 6'd1;
    s2      = {1'b0, s} + 6'd2;
    case (mode)
      MODE_MERGE2: mapped = ((off >> s1) << s1) | ((off & lo_mask) << 1) | ((off >> s) & AW'(1));
      MODE_MERGE4: mapped = ((off >> s2) << s2) | ((off & lo_mask) << 2) | ((off >> s) & AW'(3));
      default:     mapped = off;
    endcase

    issue_mask = in_range ? pmask : 2'b00;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port_a <= '0;
      mask_q <= '0;
    end else if (load) begin
      port_a <= dst + PW'(mapped);
      mask_q <= issue_mask;
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: ioctl bytes -> remapped toggle writes on two SDRAM ports, plus post-load core reset.
// Optional feature macro: ROM_DL_CHECKSUM_EN (16-bit sum of committed in-range bytes on dl_sum).
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int          NREG = 4,
  parameter int          AW   = 25,
  parameter int          PW   = 24,
  parameter int unsigned HOLD = 16'hffff
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ioctl_downl,
  input  logic                      ioctl_wr,
  input  logic [AW-1:0]             ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  output logic                      ioctl_ack,
  input  logic [NREG-1:0][AW-1:0]   region_base,
  input  logic [AW-1:0]             region_end,
  input  logic [NREG-1:0][1:0]      region_mode,
  input  logic [NREG-1:0][4:0]      region_shift,
  input  logic [NREG-1:0][PW-1:0]   region_dst,
  input  logic [NREG-1:0][1:0]      region_port,
  rom_dl_router_if.master           sdram,
  input  logic                      ext_reset,
  input  logic                      load_clear,
  output logic                      core_reset,
  output logic                      rom_loaded,
  output logic                      overrun,
  output logic [15:0]               dl_sum
);

  localparam int CW = $clog2(HOLD + 1);

  rom_dl_state_e state, state_d;

  logic          wr_q, downl_q;
  logic          wr_rise, downl_rise, downl_fall;
  logic          capture, issue, acks_match;
  logic [AW-1:0] addr_q;
  logic [7:0]    data_q;
  logic          req1_q, req2_q;
  logic          map_in_range;
  logic [1:0]    map_issue_mask;
  logic [1:0]    map_mask_q;
  logic [PW-1:0] map_a;
  logic [CW-1:0] cnt;

  assign wr_rise    = ioctl_wr & ~wr_q;
  assign downl_rise = ioctl_downl & ~downl_q;
  assign downl_fall = ~ioctl_downl & downl_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    // NOTE: registers use <= so every flop samples pre-edge values, independent of statement order.
    if (reset) begin
      wr_q    <= 1'b0;
      downl_q <= 1'b0;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
    end
  end

  rom_dl_addr_map #(.NREG(NREG), .AW(AW), .PW(PW)) u_map (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .load         (issue),
    .addr         (addr_q),
    .region_base  (region_base),
    .region_end   (region_end),
    .region_mode  (region_mode),
    .region_shift (region_shift),
    .region_dst   (region_dst),
    .region_port  (region_port),
    .in_range     (map_in_range),
    .issue_mask   (map_issue_mask),
    .port_a       (map_a),
    .mask_q       (map_mask_q)
  );

  // Only ports that were actually toggled must have caught up.
  assign acks_match = (~map_mask_q[0] | (req1_q == sdram.port1_ack)) &
                      (~map_mask_q[1] | (req2_q == sdram.port2_ack));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    capture   = 1'b0;
    issue     = 1'b0;
    ioctl_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_rise && ioctl_downl) begin
          capture = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = map_in_range ? ST_WAIT : ST_ACK;
      end
      ST_WAIT: begin
        if (acks_match) state_d = ST_ACK;
      end
      ST_ACK: begin
        ioctl_ack = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (capture) begin
      addr_q <= ioctl_addr;
      data_q <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req1_q <= 1'b0;
      req2_q <= 1'b0;
    end else if (issue) begin
      req1_q <= req1_q ^ map_issue_mask[0];
      req2_q <= req2_q ^ map_issue_mask[1];
    end
  end

  assign sdram.port1_req = req1_q;
  assign sdram.port2_req = req2_q;
  assign sdram.port_a    = map_a;
  assign sdram.port_ds   = {map_a[0], ~map_a[0]};
  assign sdram.port_d    = {data_q, data_q};

  // A byte arriving while busy is dropped; the flag survives until the next download starts.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                             overrun <= 1'b0;
    else if (downl_rise)                   overrun <= 1'b0;
    else if (wr_rise && state != ST_IDLE)  overrun <= 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)           rom_loaded <= 1'b0;
    else if (load_clear) rom_loaded <= 1'b0;
    else if (downl_fall) rom_loaded <= 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt        <= CW'(HOLD);
      core_reset <= 1'b1;
    end else begin
      if (ext_reset || !rom_loaded) cnt <= CW'(HOLD);
      else if (cnt != '0)           cnt <= cnt - CW'(1);
      core_reset <= ext_reset | ioctl_downl | ~rom_loaded | (cnt == CW'(1));
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic        in_range_q;
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      in_range_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      if (issue) in_range_q <= map_in_range;
      if (downl_rise)
        sum_q <= '0;
      else if (state == ST_ACK && in_range_q && !rom_loaded)
        sum_q <= sum_q + {8'h00, data_q};
    end
  end

  assign dl_sum = sum_q;
`else
  assign dl_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: mapping table, overrun, post-load reset, checksum, async reset.
module tb_rom_dl_router;

  localparam int          NREG = 4;
  localparam int          AW   = 25;
  localparam int          PW   = 24;
  localparam int unsigned HOLD = 8;

`ifdef ROM_DL_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'h0111;
`else
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic                    ioctl_downl, ioctl_wr;
  logic [AW-1:0]           ioctl_addr;
  logic [7:0]              ioctl_dout;
  logic                    ioctl_ack;
  logic [NREG-1:0][AW-1:0] region_base;
  logic [AW-1:0]           region_end;
  logic [NREG-1:0][1:0]    region_mode;
  logic [NREG-1:0][4:0]    region_shift;
  logic [NREG-1:0][PW-1:0] region_dst;
  logic [NREG-1:0][1:0]    region_port;
  logic                    ext_reset, load_clear;
  logic                    core_reset, rom_loaded, overrun;
  logic [15:0]             dl_sum;

  rom_dl_router_if #(.PW(PW)) sif ();

  rom_dl_router #(.NREG(NREG), .AW(AW), .PW(PW), .HOLD(HOLD)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_downl  (ioctl_downl),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .ioctl_ack    (ioctl_ack),
    .region_base  (region_base),
    .region_end   (region_end),
    .region_mode  (region_mode),
    .region_shift (region_shift),
    .region_dst   (region_dst),
    .region_port  (region_port),
    .sdram        (sif),
    .ext_reset    (ext_reset),
    .load_clear   (load_clear),
    .core_reset   (core_reset),
    .rom_loaded   (rom_loaded),
    .overrun      (overrun),
    .dl_sum       (dl_sum)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM side: each port echoes its req after lat cycles of mismatch.
  int lat = 3;
  int d1, d2;
  int ack_cnt;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sif.port1_ack <= 1'b0;
      d1            <= 0;
    end else if (sif.port1_req != sif.port1_ack) begin
      if (d1 >= lat - 1) begin
        sif.port1_ack <= sif.port1_req;
        d1            <= 0;
      end else d1 <= d1 + 1;
    end
  end

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sif.port2_ack <= 1'b0;
      d2            <= 0;
    end else if (sif.port2_req != sif.port2_ack) begin
      if (d2 >= lat - 1) begin
        sif.port2_ack <= sif.port2_req;
        d2            <= 0;
      end else d2 <= d2 + 1;
    end
  end

  always @(posedge clk_sys or posedge reset) begin
    if (reset)          ack_cnt <= 0;
    else if (ioctl_ack) ack_cnt <= ack_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d,
                           output int cyc, output logic [PW-1:0] a_at2, output logic [1:0] req_at2);
    cyc     = -1;
    a_at2   = '0;
    req_at2 = '0;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (k == 1) ioctl_wr = 1'b0;
      if (k == 2) begin
        a_at2   = sif.port_a;
        req_at2 = {sif.port2_req, sif.port1_req};
      end
      if (ioctl_ack) begin
        cyc = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            lat;
    logic          in_range;
    logic [PW-1:0] exp_a;
    logic [1:0]    exp_ds;
    logic [1:0]    exp_mask;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

  initial begin
    int            cyc, ac0;
    logic [PW-1:0] a2;
    logic [1:0]    r2, rb;
    logic          bad;

    vec[0] = '{25'h0000123, 8'h5A, 3, 1'b1, 24'h000123, 2'b10, 2'b01};
    vec[1] = '{25'h0030005, 8'h11, 3, 1'b1, 24'h000016, 2'b01, 2'b10};
    vec[2] = '{25'h0068003, 8'h22, 3, 1'b1, 24'h058007, 2'b10, 2'b11};
    vec[3] = '{25'h0080010, 8'h33, 1, 1'b1, 24'h100010, 2'b01, 2'b01};
    vec[4] = '{25'h0090000, 8'h44, 3, 1'b0, 24'h000000, 2'b00, 2'b00};
    vec[5] = '{25'h0057FFF, 8'h55, 3, 1'b1, 24'h05FFFC, 2'b01, 2'b10};
    vec[6] = '{25'h0058000, 8'h66, 3, 1'b1, 24'h058000, 2'b01, 2'b11};
    vec[7] = '{25'h008FFFF, 8'h77, 3, 1'b1, 24'h10FFFF, 2'b10, 2'b01};
    vec[8] = '{25'h0072BCD, 8'h88, 3, 1'b1, 24'h06D79B, 2'b10, 2'b11};

    region_base  = {25'h0080000, 25'h0058000, 25'h0010000, 25'h0000000};
    region_end   = 25'h0090000;
    region_mode  = {2'd0, 2'd1, 2'd2, 2'd0};
    region_shift = {5'd0, 5'd16, 5'd16, 5'd0};
    region_dst   = {24'h100000, 24'h058000, 24'h000000, 24'h000000};
    region_port  = {2'b01, 2'b11, 2'b10, 2'b01};

    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    ext_reset   = 1'b0;
    load_clear  = 1'b0;

    repeat (3) @(negedge clk_sys);
    check("rst_req", {sif.port2_req, sif.port1_req}, 2'b00);
    check("rst_port_a", sif.port_a, 24'h0);
    check("rst_ioctl_ack", ioctl_ack, 1'b0);
    check("rst_rom_loaded", rom_loaded, 1'b0);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_overrun", overrun, 1'b0);
    check("rst_dl_sum", dl_sum, 16'h0);
    reset = 1'b0;

    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("dl_core_reset", core_reset, 1'b1);

    for (int i = 0; i < NV; i++) begin
      lat = vec[i].lat;
      rb  = {sif.port2_req, sif.port1_req};
      ac0 = ack_cnt;
      send_byte(vec[i].addr, vec[i].data, cyc, a2, r2);
      check($sformatf("v%0d_latency", i), cyc, vec[i].in_range ? 3 + vec[i].lat : 2);
      check($sformatf("v%0d_req_at_n2", i), r2 ^ rb, vec[i].exp_mask);
      check($sformatf("v%0d_req_final", i), {sif.port2_req, sif.port1_req} ^ rb, vec[i].exp_mask);
      if (vec[i].in_range) begin
        check($sformatf("v%0d_port_a_at_n2", i), a2, vec[i].exp_a);
        check($sformatf("v%0d_port_a_held", i), sif.port_a, vec[i].exp_a);
        check($sformatf("v%0d_port_ds", i), sif.port_ds, vec[i].exp_ds);
        check($sformatf("v%0d_port_d", i), sif.port_d, {vec[i].data, vec[i].data});
      end
      @(negedge clk_sys);
      check($sformatf("v%0d_ack_one_cycle", i), ioctl_ack, 1'b0);
      check($sformatf("v%0d_ack_count", i), ack_cnt - ac0, 1);
    end
    check("no_overrun_yet", overrun, 1'b0);

    // Second strobe lands while the first byte is still waiting for the SDRAM.
    lat = 6;
    rb  = {sif.port2_req, sif.port1_req};
    ac0 = ack_cnt;
    @(negedge clk_sys);
    ioctl_addr = 25'h0000200; ioctl_dout = 8'h33; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'h0000300; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("ovr_flag", overrun, 1'b1);
    cyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      if (ioctl_ack) begin
        cyc = k;
        break;
      end
    end
    check("ovr_ack_seen", cyc >= 0, 1'b1);
    check("ovr_port_a", sif.port_a, 24'h000200);
    check("ovr_port_d", sif.port_d, 16'h3333);
    repeat (12) @(negedge clk_sys);
    check("ovr_single_ack", ack_cnt - ac0, 1);
    check("ovr_single_write", {sif.port2_req, sif.port1_req} ^ rb, 2'b01);

    // End of download: one-cycle core reset pulse after HOLD-1 low cycles.
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    check("pl_rom_loaded", rom_loaded, 1'b1);
    check("pl_core_reset_first", core_reset, 1'b1);
    check("pl_overrun_sticky", overrun, 1'b1);
    bad = 1'b0;
    for (int k = 1; k < HOLD; k++) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b0) bad = 1'b1;
    end
    check("pl_hold_low", bad, 1'b0);
    @(negedge clk_sys);
    check("pl_pulse_high", core_reset, 1'b1);
    @(negedge clk_sys);
    check("pl_pulse_end", core_reset, 1'b0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      if (core_reset !== 1'b0) bad = 1'b1;
    end
    check("pl_stays_low", bad, 1'b0);

    load_clear = 1'b1;
    @(negedge clk_sys);
    load_clear = 1'b0;
    @(negedge clk_sys);
    check("lc_rom_loaded", rom_loaded, 1'b0);
    bad = 1'b0;
    repeat (12) begin
      if (core_reset !== 1'b1) bad = 1'b1;
      @(negedge clk_sys);
    end
    check("lc_core_reset_held", bad, 1'b0);

    // Fresh download: clears overrun and the checksum; the out-of-range byte is not summed.
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
    check("dl2_overrun_cleared", overrun, 1'b0);
    lat = 3;
    send_byte(25'h0000000, 8'hFF, cyc, a2, r2);
    send_byte(25'h0000001, 8'h02, cyc, a2, r2);
    send_byte(25'h0095000, 8'h80, cyc, a2, r2);
    check("dl2_oor_latency", cyc, 2);
    send_byte(25'h0000002, 8'h10, cyc, a2, r2);
    check("dl2_last_latency", cyc, 6);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("dl2_rom_loaded", rom_loaded, 1'b1);
    check("dl2_dl_sum", dl_sum, EXP_SUM);

    // Asynchronous reset while a write is outstanding.
    ioctl_downl = 1'b1;
    lat = 30;
    rb  = {sif.port2_req, sif.port1_req};
    @(negedge clk_sys);
    ioctl_addr = 25'h0000010; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("ar_req_toggled", {sif.port2_req, sif.port1_req} ^ rb, 2'b01);
    check("ar_req_before", {sif.port2_req, sif.port1_req}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("ar_req_cleared", {sif.port2_req, sif.port1_req}, 2'b00);
    check("ar_port_a", sif.port_a, 24'h0);
    check("ar_rom_loaded", rom_loaded, 1'b0);
    check("ar_core_reset", core_reset, 1'b1);
    check("ar_ioctl_ack", ioctl_ack, 1'b0);
    check("ar_dl_sum", dl_sum, 16'h0);
    repeat (2) @(negedge clk_sys);
    reset       = 1'b0;
    ioctl_downl = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("ar_idle_no_ack", ioctl_ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
